// File: rtl/pwm_fader_pkg.sv
// Shared definitions for the pwm_fader breathing-envelope generator:
// phase encodings, phase width and default on-count width.
package pwm_fader_pkg;

  localparam int PHASE_W    = 3;
  localparam int DEFAULT_BW = 8;

  localparam logic [PHASE_W-1:0] IDLE      = 3'd0;
  localparam logic [PHASE_W-1:0] RAMP_UP   = 3'd1;
  localparam logic [PHASE_W-1:0] HOLD_HIGH = 3'd2;
  localparam logic [PHASE_W-1:0] RAMP_DOWN = 3'd3;
  localparam logic [PHASE_W-1:0] HOLD_LOW  = 3'd4;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE      = IDLE,
    ST_RAMP_UP   = RAMP_UP,
    ST_HOLD_HIGH = HOLD_HIGH,
    ST_RAMP_DOWN = RAMP_DOWN,
    ST_HOLD_LOW  = HOLD_LOW
  } state_e;

endpackage

// File: rtl/pwm_fader_counter.sv
// Free-running up-counter with asynchronous reset and a synchronous clear
// that takes priority over counting; used as the step-tick prescaler.
module pwm_fader_counter #(
  parameter int BW = 16
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          nrstSync_i,
  input  logic          en_i,
  output logic [BW-1:0] cnt_o
);

  logic [BW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (nrstSync_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pwm_fader.sv
// Breathing on-count generator feeding pwm onCnt_i: ramp up, hold, ramp down,
// hold, repeat. Define PWM_FADER_GAMMA_EN to square the output (one extra clock).
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int BW          = DEFAULT_BW,
  parameter int PRESCALE_BW = 16,
  parameter int HOLD_BW     = 8
) (
  input  logic                   clk_i,
  input  logic                   nrst_i,
  input  logic                   en_i,
  input  logic [PRESCALE_BW-1:0] stepDiv_i,
  input  logic [BW-1:0]          stepSize_i,
  input  logic [BW-1:0]          maxCnt_i,
  input  logic [HOLD_BW-1:0]     holdSteps_i,
  output logic [BW-1:0]          onCnt_o,
  output logic [PHASE_W-1:0]     phase_o,
  output logic                   cycleDone_o
);

  state_e               state_d, state_q;
  logic [BW-1:0]        lin_d, lin_q;
  logic [HOLD_BW-1:0]   hold_d, hold_q;
  logic                 done_d, done_q;

  logic [PRESCALE_BW-1:0] pre_cnt, div_eff, div_m1;
  logic [BW-1:0]          step_eff, lin_up, lin_dn;
  logic                   tick, overrange, pre_clr, hold_end;

  function automatic logic [BW-1:0] sat_add(input logic [BW-1:0] a,
                                            input logic [BW-1:0] s,
                                            input logic [BW-1:0] peak);
    logic [BW:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    return (sum > {1'b0, peak}) ? peak : sum[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] sat_sub(input logic [BW-1:0] a,
                                            input logic [BW-1:0] s);
    return (a > s) ? (a - s) : '0;
  endfunction

  assign div_eff  = (stepDiv_i == '0) ? PRESCALE_BW'(1) : stepDiv_i;
  assign div_m1   = div_eff - PRESCALE_BW'(1);
  assign step_eff = (stepSize_i == '0) ? BW'(1) : stepSize_i;

  // A lowered divider can leave the prescaler past its terminal count; clear it without a tick.
  assign tick      = (state_q != ST_IDLE) && (pre_cnt == div_m1);
  assign overrange = (pre_cnt > div_m1);
  assign pre_clr   = tick | (state_q == ST_IDLE) | overrange | ~en_i;

  pwm_fader_counter #(
    .BW (PRESCALE_BW)
  ) u_prescaler (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .nrstSync_i (pre_clr),
    .en_i       (1'b1),
    .cnt_o      (pre_cnt)
  );

  assign lin_up   = sat_add(lin_q, step_eff, maxCnt_i);
  assign lin_dn   = sat_sub(lin_q, step_eff);
  assign hold_end = (hold_q == holdSteps_i);

  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
      lin_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RAMP_UP;
          lin_d   = '0;
          hold_d  = '0;
        end
        ST_RAMP_UP: if (tick) begin
          lin_d = lin_up;
          if (lin_up == maxCnt_i) begin
            state_d = ST_HOLD_HIGH;
            hold_d  = '0;
          end
        end
        ST_HOLD_HIGH: if (tick) begin
          if (hold_end) state_d = ST_RAMP_DOWN;
          else          hold_d  = hold_q + HOLD_BW'(1);
        end
        ST_RAMP_DOWN: if (tick) begin
          lin_d = lin_dn;
          if (lin_dn == '0) begin
            state_d = ST_HOLD_LOW;
            hold_d  = '0;
          end
        end
        ST_HOLD_LOW: if (tick) begin
          if (hold_end) begin
            state_d = ST_RAMP_UP;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_BW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          lin_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
      lin_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign phase_o     = state_q;
  assign cycleDone_o = done_q;

`ifdef PWM_FADER_GAMMA_EN
  logic [2*BW-1:0] sq;
  logic [BW-1:0]   gamma_d, gamma_q;

  always_comb begin
    sq      = {{BW{1'b0}}, lin_q} * {{BW{1'b0}}, lin_q};
    gamma_d = sq[2*BW-1:BW];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      gamma_q <= '0;
    end else begin
      gamma_q <= gamma_d;
    end
  end

  assign onCnt_o = gamma_q;
`else
  assign onCnt_o = lin_q;
`endif

endmodule

// File: tb/tb_pwm_fader.sv
// Scoreboard bench for pwm_fader: per-clock expectations from a behavioural
// envelope model are queued by the stimulus and popped by an independent monitor.
module tb_pwm_fader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [15:0] div;
  logic [7:0]  ssz, mx, hs;
  logic [7:0]  onCnt_o;
  logic [2:0]  phase_o;
  logic        cycleDone_o;

  always #5 clk = ~clk;

  pwm_fader #(.BW(8), .PRESCALE_BW(16), .HOLD_BW(8)) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .en_i        (en),
    .stepDiv_i   (div),
    .stepSize_i  (ssz),
    .maxCnt_i    (mx),
    .holdSteps_i (hs),
    .onCnt_o     (onCnt_o),
    .phase_o     (phase_o),
    .cycleDone_o (cycleDone_o)
  );

  typedef struct {int on; int ph; int done;} exp_t;
  exp_t q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Envelope model: phase number, linear level, ticks dwelt in a hold, clocks into current tick.
  int m_ph, m_lin, m_dwell, m_clk, m_done, m_gam;

  task automatic model_reset();
    m_ph = 0; m_lin = 0; m_dwell = 0; m_clk = 0; m_done = 0; m_gam = 0;
  endtask

  task automatic model_step();
    int d, s, peak;
    bit tick;
    exp_t e;
    m_gam  = (m_lin * m_lin) / 256;
    m_done = 0;
    d    = (div == 16'd0) ? 1 : int'(div);
    s    = (ssz == 8'd0) ? 1 : int'(ssz);
    peak = int'(mx);
    if (!en) begin
      m_ph = 0; m_lin = 0; m_dwell = 0; m_clk = 0;
    end else if (m_ph == 0) begin
      m_ph = 1; m_clk = 0;
    end else begin
      tick  = (m_clk == d - 1);
      m_clk = (m_clk + 1 >= d) ? 0 : m_clk + 1;
      if (tick) begin
        case (m_ph)
          1: begin
            m_lin = (m_lin + s > peak) ? peak : m_lin + s;
            if (m_lin == peak) begin m_ph = 2; m_dwell = 0; end
          end
          2: if (m_dwell == int'(hs)) m_ph = 3; else m_dwell++;
          3: begin
            m_lin = (m_lin > s) ? m_lin - s : 0;
            if (m_lin == 0) begin m_ph = 4; m_dwell = 0; end
          end
          4: if (m_dwell == int'(hs)) begin m_ph = 1; m_done = 1; end else m_dwell++;
          default: m_ph = 0;
        endcase
      end
    end
`ifdef PWM_FADER_GAMMA_EN
    e.on = m_gam;
`else
    e.on = m_lin;
`endif
    e.ph   = m_ph;
    e.done = m_done;
    q.push_back(e);
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (int'(phase_o) != ph && n < 400) begin
      step();
      n++;
    end
    check("wait_phase", int'(phase_o), ph);
  endtask

  always @(posedge clk) begin
    #1;
    if (nrst && q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if ({onCnt_o, phase_o, cycleDone_o} !== {8'(mon_e.on), 3'(mon_e.ph), 1'(mon_e.done)}) begin
        errors++;
        $display("FAIL scoreboard at %0t: got on=%0d ph=%0d done=%0b expected on=%0d ph=%0d done=%0d",
                 $time, onCnt_o, phase_o, cycleDone_o, mon_e.on, mon_e.ph, mon_e.done);
      end
    end
  end

  int n0, n1, exp_peak, guard;

  initial begin
    nrst = 1'b1; en = 1'b0;
    div = 16'd4; ssz = 8'd64; mx = 8'd200; hs = 8'd2;
    model_reset();
    #1 nrst = 1'b0;
    #1;
    check("reset_on", int'(onCnt_o), 0);
    check("reset_phase", int'(phase_o), 0);
    check("reset_done", int'(cycleDone_o), 0);
    @(negedge clk);
    nrst = 1'b1;
    step(); step();

    // Full cycle: cycleDone 56 clocks after RAMP_UP entry.
    en = 1'b1;
    n0 = -1; n1 = -1;
    for (int i = 0; i < 70; i++) begin
      step();
      if (phase_o == 3'd1 && n0 < 0) n0 = i;
      if (cycleDone_o && n1 < 0) n1 = i;
    end
    check("cycle_entry", n0, 0);
    check("cycle_len", n1 - n0, 56);

    // Peak lowered while holding high.
    wait_phase(2);
    mx = 8'd100;
    wait_phase(3);
    wait_phase(1);
    wait_phase(2);
    step();
`ifdef PWM_FADER_GAMMA_EN
    exp_peak = (100 * 100) / 256;
`else
    exp_peak = 100;
`endif
    check("peak_lowered", int'(onCnt_o), exp_peak);

    // Enable drop during ramp-down, then restart.
    wait_phase(3);
    en = 1'b0;
    step();
    check("en_drop_phase", int'(phase_o), 0);
    check("en_drop_done", int'(cycleDone_o), 0);
    en = 1'b1;
    step();
    check("reenable_phase", int'(phase_o), 1);
    for (int i = 0; i < 10; i++) step();

    // Asynchronous reset with the linear level at 128.
    mx = 8'd200;
    guard = 0;
    while (!(m_ph == 1 && m_lin == 128) && guard < 400) begin
      step();
      guard++;
    end
    check("reach_128", m_lin, 128);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_on", int'(onCnt_o), 0);
    check("async_rst_phase", int'(phase_o), 0);
    check("async_rst_done", int'(cycleDone_o), 0);
    q.delete();
    model_reset();
    @(negedge clk);
    nrst = 1'b1;

    // Degenerate controls: divider, step and hold all at their minimum.
    div = 16'd0; ssz = 8'd0; mx = 8'd3; hs = 8'd0;
    for (int i = 0; i < 40; i++) step();

    // Zero peak.
    mx = 8'd0;
    for (int i = 0; i < 20; i++) step();

    // Randomized controls and enable.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        div = 16'($urandom_range(0, 5));
        ssz = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
        mx  = 8'($urandom_range(0, 255));
        hs  = 8'($urandom_range(0, 3));
      end
      en = ($urandom_range(0, 99) != 0);
      step();
    end

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
